// File: rtl/cap17_pkg.sv
// Shared types and defaults for the fetch/load-store memory access controller.
package cap17_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SETTLE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_arb.sv
// Load/store-priority arbiter with a fetch starvation guard.
import cap17_pkg::*;

module mem_arb #(
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ls_req,
  input  logic take,
  output logic gnt_if,
  output logic gnt_ls
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt;
  logic          starve;

  assign starve = (cnt == CW'(STARVE_LIMIT));
  assign gnt_if = take & if_req & (~ls_req | starve);
  assign gnt_ls = take & ls_req & ~gnt_if;

  // counts load/store wins that happened while a fetch waited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt_if) begin
      cnt <= '0;
    end else if (gnt_ls) begin
      if (!if_req)
        cnt <= '0;
      else if (!starve)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Serialises fetch and load/store requests onto one split-byte memory port.
import cap17_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy
);

  state_t     state;
  logic [1:0] rst_sync;
  logic       own_ls;
  logic       take;
  logic       gnt_if;
  logic       gnt_ls;

  assign take = (state == ST_IDLE) & rst_sync[1];
  assign busy = (state != ST_IDLE);

  // no grants until release has passed two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  mem_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .if_req(if_req),
    .ls_req(ls_req),
    .take  (take),
    .gnt_if(gnt_if),
    .gnt_ls(gnt_ls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      own_ls           <= 1'b0;
      mem_address      <= '0;
      mem_datain       <= '0;
      mem_write_enable <= 1'b0;
      if_ack           <= 1'b0;
      ls_ack           <= 1'b0;
      if_data          <= '0;
      ls_rdata         <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_ls) begin
            state            <= ST_ACCESS;
            own_ls           <= 1'b1;
            mem_address      <= ls_addr;
            mem_datain       <= ls_wdata;
            mem_write_enable <= ls_we;
          end else if (gnt_if) begin
            state            <= ST_ACCESS;
            own_ls           <= 1'b0;
            mem_address      <= if_addr;
            mem_datain       <= '0;
            mem_write_enable <= 1'b0;
          end
        end
        ST_ACCESS: state <= ST_SETTLE;
        ST_SETTLE: begin
          state            <= ST_RESP;
          mem_write_enable <= 1'b0;
          if (own_ls) begin
            ls_ack <= 1'b1;
            if (!mem_write_enable)
              ls_rdata <= mem_dataout;
          end else begin
            if_ack  <= 1'b1;
            if_data <= mem_dataout;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
